// File: rtl/axi_sim_memory_pkg.sv
// ============================================================================
// Module : axi_sim_memory_pkg
// Brief  : Shared widths, FSM state type and LFSR seed for axi_sim_memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_sim_memory_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/axi_sim_memory_lfsr.sv
// ============================================================================
// Module : axi_sim_memory_lfsr
// Brief  : 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a stall flag
//          whenever its two low bits are zero. Built only with
//          AXI_SIM_MEMORY_STALL_EN defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef AXI_SIM_MEMORY_STALL_EN
module axi_sim_memory_lfsr
  import axi_sim_memory_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  output logic o_stall
);

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_feedback};
    end
  end

  assign o_stall = (r_lfsr[1:0] == 2'b00);

endmodule
`endif

`default_nettype wire

// File: rtl/axi_sim_memory.sv
// ============================================================================
// Module : axi_sim_memory
// Brief  : Word-addressed behavioural main memory with an AXI-style burst
//          slave port, one transaction in flight. Define
//          AXI_SIM_MEMORY_STALL_EN for pseudo-random back-pressure stalls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_sim_memory
  import axi_sim_memory_pkg::*;
#(
  parameter int MEM_WORDS = 4194304
)
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [AXI_ADDR_W-1:0] axi_awaddr,
  input  logic [AXI_LEN_W-1:0]  axi_awlen,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [AXI_DATA_W-1:0] axi_wdata,
  input  logic                  axi_wlast,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [AXI_ADDR_W-1:0] axi_araddr,
  input  logic [AXI_LEN_W-1:0]  axi_arlen,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic                  axi_rvalid,
  output logic [AXI_DATA_W-1:0] axi_rdata,
  input  logic                  axi_rready
);

  localparam int         c_idx_w    = $clog2(MEM_WORDS);
  localparam logic [1:0] c_st_idle  = IDLE;
  localparam logic [1:0] c_st_wdata = WDATA;
  localparam logic [1:0] c_st_wresp = WRESP;
  localparam logic [1:0] c_st_rdata = RDATA;

  reg [31:0] memory [0:MEM_WORDS-1];

  logic [1:0]              r_state;
  logic [AXI_ADDR_W-3:0]   r_word;
  logic [AXI_LEN_W-1:0]    r_len;
  logic [AXI_LEN_W-1:0]    r_beat;
  logic [c_idx_w-1:0]      w_index;
  logic                    w_stall;
  logic                    w_go;
  logic                    w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs;
  logic                    w_last_beat;
  logic                    w_unused;

`ifdef AXI_SIM_MEMORY_STALL_EN
  axi_sim_memory_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .o_stall (w_stall)
  );
`else
  assign w_stall = 1'b0;
`endif

  assign w_unused = ^{axi_awaddr[1:0], axi_araddr[1:0]};

  // Burst and out-of-range addresses both wrap by truncating to the array depth.
  assign w_index = c_idx_w'(r_word + (AXI_ADDR_W-2)'(r_beat));

  // Outputs are held low during reset and during stall cycles.
  assign w_go        = reset_n & ~w_stall;
  assign axi_awready = w_go & (r_state == c_st_idle);
  assign axi_arready = w_go & (r_state == c_st_idle);
  assign axi_wready  = w_go & (r_state == c_st_wdata);
  assign axi_bvalid  = w_go & (r_state == c_st_wresp);
  assign axi_rvalid  = w_go & (r_state == c_st_rdata);
  assign axi_rdata   = (reset_n && r_state == c_st_rdata) ? memory[w_index] : '0;

  assign w_aw_hs     = axi_awvalid & axi_awready;
  assign w_ar_hs     = axi_arvalid & axi_arready & ~axi_awvalid;
  assign w_w_hs      = axi_wvalid  & axi_wready;
  assign w_b_hs      = axi_bvalid  & axi_bready;
  assign w_r_hs      = axi_rvalid  & axi_rready;
  assign w_last_beat = (r_beat == r_len);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
      r_word  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_aw_hs) begin
            r_state <= c_st_wdata;
            r_word  <= axi_awaddr[AXI_ADDR_W-1:2];
            r_len   <= axi_awlen;
            r_beat  <= '0;
          end else if (w_ar_hs) begin
            r_state <= c_st_rdata;
            r_word  <= axi_araddr[AXI_ADDR_W-1:2];
            r_len   <= axi_arlen;
            r_beat  <= '0;
          end
        end
        c_st_wdata: begin
          if (w_w_hs) begin
            r_beat <= r_beat + 8'd1;
            if (axi_wlast || w_last_beat) begin
              r_state <= c_st_wresp;
            end
          end
        end
        c_st_wresp: begin
          if (w_b_hs) begin
            r_state <= c_st_idle;
          end
        end
        c_st_rdata: begin
          if (w_r_hs) begin
            if (w_last_beat) begin
              r_state <= c_st_idle;
              r_beat  <= '0;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Storage has no reset so preloaded and committed contents survive it.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      memory[w_index] <= axi_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_sim_memory.sv
// ============================================================================
// Module : tb_axi_sim_memory
// Brief  : Directed bench for axi_sim_memory with a transaction-level model
//          and a per-cycle output compare process.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_sim_memory;

  localparam int          MEM_WORDS = 4096;
  localparam int unsigned c_mask    = MEM_WORDS - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rready = 1'b0;
  logic [4:0]  outs;

  always #5 clk = ~clk;

  axi_sim_memory #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .axi_awaddr  (awaddr),
    .axi_awlen   (awlen),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_wdata   (wdata),
    .axi_wlast   (wlast),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .axi_araddr  (araddr),
    .axi_arlen   (arlen),
    .axi_arvalid (arvalid),
    .axi_arready (arready),
    .axi_rvalid  (rvalid),
    .axi_rdata   (rdata),
    .axi_rready  (rready)
  );

  assign outs = {awready, arready, wready, bvalid, rvalid};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level reference: sparse memory image plus expected read beats.
  typedef enum int {P_IDLE, P_WRITE, P_RESP, P_READ} phase_t;
  logic [31:0] model_mem [int unsigned];
  logic [31:0] rq [$];
  phase_t      ph = P_IDLE;
  int unsigned w_word;
  int          w_len, w_cnt;
  int          bcount = 0;

  function automatic logic [31:0] model_rd(input int unsigned idx);
    int unsigned k;
    k = idx & c_mask;
    return model_mem.exists(k) ? model_mem[k] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("outs_in_reset", 32'(outs), 32'h0);
      ph = P_IDLE;
      rq.delete();
    end else begin
      case (ph)
        P_IDLE: begin
          chk("outs_idle", 32'(outs), 32'b11000);
          if (awvalid) begin
            ph = P_WRITE; w_word = awaddr >> 2; w_len = int'(awlen); w_cnt = 0;
          end else if (arvalid) begin
            ph = P_READ;
            for (int i = 0; i <= int'(arlen); i++) rq.push_back(model_rd((araddr >> 2) + i));
          end
        end
        P_WRITE: begin
          chk("outs_write", 32'(outs), 32'b00100);
          if (wvalid) begin
            model_mem[(w_word + w_cnt) & c_mask] = wdata;
            if (wlast || w_cnt == w_len) ph = P_RESP;
            w_cnt++;
          end
        end
        P_RESP: begin
          chk("outs_resp", 32'(outs), 32'b00010);
          if (bready) begin
            ph = P_IDLE; bcount++;
          end
        end
        P_READ: begin
          chk("outs_read", 32'(outs), 32'b00001);
          chk("rdata", rdata, (rq.size() > 0) ? rq[0] : 32'hDEADBEEF);
          if (rready && rq.size() > 0) begin
            void'(rq.pop_front());
            if (rq.size() == 0) ph = P_IDLE;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  logic [31:0] rd_got [$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] l,
                          input logic [31:0] base, input int bdelay);
    int n;
    awaddr = a; awlen = l; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 1000);
    chk("aw_accept", 32'(awready), 32'd1);
    tick(); awvalid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      wdata = base + i; wlast = (i == int'(l)); wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 1000);
      chk("w_accept", 32'(wready), 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat (bdelay) tick();
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 1000);
    chk("b_accept", 32'(bvalid), 32'd1);
    tick(); bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] l,
                         input bit toggle, input int reset_at);
    int n, got, k;
    rd_got.delete();
    araddr = a; arlen = l; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 1000);
    chk("ar_accept", 32'(arready), 32'd1);
    tick(); arvalid = 1'b0;
    got = 0; k = 0; n = 0;
    while (got <= int'(l) && n < 1000) begin
      rready = toggle ? (k % 2 == 0) : 1'b1;
      if (got == reset_at) reset_n = 1'b0;
      @(negedge clk);
      if (rvalid && rready) begin
        rd_got.push_back(rdata); got++;
      end
      tick(); k++; n++;
      if (!reset_n) begin
        reset_n = 1'b1;
        break;
      end
    end
    rready = 1'b0;
    if (reset_at < 0) chk("r_beats", 32'(got), 32'(int'(l) + 1));
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", 32'(outs), 32'h0);
    tick(); reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(outs), 32'b11000);
    tick();

    // Preload words 0x100.. with their offset, then stream them back.
    do_write(32'h400, 8'd15, 32'h0, 0);
    do_read(32'h400, 8'd15, 1'b0, -1);
    chk("rd0", rd_got[0], 32'd0);
    chk("rd7", rd_got[7], 32'd7);
    chk("rd15", rd_got[15], 32'd15);

    // Writeback with a slow response acceptance.
    do_write(32'h800, 8'd15, 32'hA0, 5);
    for (int i = 0; i < 16; i++) chk("mem_wb", dut.memory[32'h200 + i], 32'hA0 + i);
    chk("model_pin", model_rd(32'h20A), 32'hAA);

    // Simultaneous request: the write (wrapping past the top) goes first.
    araddr = 32'h800; arlen = 8'd3; arvalid = 1'b1;
    do_write(32'h3FF8, 8'd3, 32'hC0, 0);
    do_read(32'h800, 8'd3, 1'b0, -1);
    chk("pend_rd2", rd_got[2], 32'hA2);
    chk("wrap_mem_fff", dut.memory[32'hFFF], 32'hC1);
    chk("wrap_mem_0", dut.memory[0], 32'hC2);

    // Out-of-range start address wraps; rready toggles every cycle.
    do_read(32'hFFFF_FFF8, 8'd3, 1'b1, -1);
    chk("tog_rd0", rd_got[0], 32'hC0);
    chk("tog_rd2", rd_got[2], 32'hC2);
    chk("tog_rd3", rd_got[3], 32'hC3);

    // Reset while beat 3 is on the bus, then a clean read.
    do_read(32'h400, 8'd15, 1'b0, 3);
    @(negedge clk);
    chk("idle_after_abort", 32'(outs), 32'b11000);
    tick();
    do_read(32'h400, 8'd15, 1'b0, -1);
    chk("post_rst_rd5", rd_got[5], 32'd5);
    chk("post_rst_rd15", rd_got[15], 32'd15);

    chk("b_count", 32'(bcount), 32'd3);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
